core_feeder: RTL and testbench
==============================

Name: core_feeder

Overview:
- Sequencer on the driving end of the core's rdy/forward/backward/x/e, vld/y interface.
- Buffers one input vector from a host stream and replays it to the core as a forward pass, then captures y.
- Computes the scaled error against a target and replays the vector again as a backward (weight-update) pass.
- Returns y and the error to the host over a valid/ready handshake.

Parameters:
- N, 100: vector length; one x word per core weight index.
- DW, 16: data width, signed Q8.8.
- LR_SHIFT, 4: arithmetic right shift applied to the raw error to form e.
- TIMEOUT, 64: maximum cycles to wait for core vld after the forward pass.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
- in_valid  input  1  host input word valid
- in_ready  output  1  feeder accepts input word
- in_data  input  DW  input word x[i]
- in_last  input  1  final word of the vector
- tgt  input  DW  target value, sampled on the beat that completes the load
- rdy  output  1  x/e on the core interface are valid this cycle
- forward  output  1  forward-pass beat
- backward  output  1  backward-pass beat
- x  output  DW  vector element driven to the core
- e  output  DW  error driven to the core, constant during the backward pass
- vld  input  1  core result valid
- y  input  DW  core result
- out_valid  output  1  result available to host
- out_ready  input  1  host accepts result
- out_y  output  DW  captured y
- out_err  output  DW  e used for the update
- timeout  output  1  sticky flag: core vld did not arrive; cleared only by reset

Behaviour:
- Reset: all outputs are 0, state is IDLE, counter i is 0, and timeout is 0 on the next edge. Reset mid-pass aborts immediately; buffer contents are don't-care.
- States: IDLE, LOAD, FWD, WAIT_Y, ERR, BWD, DONE.
- IDLE:
  - in_ready = 1.
  - The first accepted word goes to buf[0], i=1, state → LOAD.
  - If that word has in_last, or N=1, the load is complete and the next state is FWD.
- LOAD:
  - in_ready = 1 while i < N.
  - Each accepted beat writes buf[i] and increments i.
  - The load completes on in_last or on the N-th word; tgt is latched on that beat.
  - On in_last with i < N-1, the remaining entries are zero-padded. Padding completes before FWD starts (one write per cycle or a bulk clear; either is acceptable).
  - in_ready = 0 from the cycle after completion until return to IDLE.
- FWD:
  - For exactly N consecutive cycles: rdy=1, forward=1, backward=0, x=buf[k] for k=0..N-1, e=0.
  - The beat order is the core's weight index order.
- WAIT_Y:
  - rdy=forward=0. A wait counter starts at 0.
  - On vld=1: capture y into out_y, state → ERR.
  - If no vld after TIMEOUT cycles: set timeout, out_y=0, state → DONE, skip training.
  - vld seen during FWD is ignored.
- ERR, one cycle:
  - raw = tgt − out_y, computed at DW+1 bits and saturated to signed DW (0x7FFF / 0x8000).
  - e_reg = raw >>> LR_SHIFT, arithmetic shift.
  - out_err = e_reg.
- BWD:
  - For N consecutive cycles: rdy=1, backward=1, forward=0, x=buf[k], e=e_reg.
- DONE:
  - out_valid=1, with out_y and out_err stable until out_valid && out_ready.
  - Then state → IDLE and in_ready=1 on the following cycle.
- forward and backward are never both 1. rdy=1 only in FWD/BWD.
- Minimum latency, first input beat to out_valid, full-length vector: N (load) + N (FWD) + vld delay + 1 (ERR) + N (BWD) + 1 cycles.

Optional Feature:
- Macro: FEEDER_TRAIN_EN.
- Defined: full behaviour as above.
- Undefined (inference only):
  - ERR and BWD are removed; WAIT_Y goes directly to DONE on vld.
  - backward and e are tied to 0; out_err is 0.
  - tgt is unused.

Test Plan:
- N=4, load 0x0100,0x0200,0x0300,0x0400 with in_last on the 4th, tgt=0x0800; core model returns y=0x0500 two cycles after FWD → forward high 4 cycles with x in order; e=(0x0300>>>4)=0x0030 during 4 backward cycles; out_y=0x0500, out_err=0x0030.
- N=4, in_last on the 2nd word (0x0100,0x0200) → FWD x sequence 0x0100,0x0200,0x0000,0x0000.
- tgt=0x7FFF, y=0x8000 → raw saturates to 0x7FFF; e=0x07FF with LR_SHIFT=4.
- Core never asserts vld, TIMEOUT=64 → timeout=1 after 64 WAIT_Y cycles; no backward beats; out_valid with out_y=0.
- out_ready held low for 10 cycles in DONE → out_valid/out_y/out_err stable; in_ready stays 0 until the handshake completes.
- rst=0 asserted mid-FWD → next edge: forward=rdy=0, in_ready=0 while reset is held; after release, IDLE with in_ready=1 and timeout=0.

Source files
------------

// File: rtl/core_feeder_if.sv
// Purpose : bundles the host input stream, core rdy/forward/backward/x/e, vld/y
//           interface and host result handshake of the core feeder.
// Latency : n/a (wiring only).
// Backpressure: n/a; master = feeder side, slave = host/core side.
// Signals : in_valid/in_ready/in_data/in_last/tgt   host -> feeder vector load
//           rdy/forward/backward/x/e                 feeder -> core beats
//           vld/y                                    core -> feeder result
//           out_valid/out_ready/out_y/out_err        feeder -> host result
//           timeout                                  sticky core-timeout flag
interface core_feeder_if #(
   parameter int DW = 16
);
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          in_last;
   logic [DW-1:0] tgt;

   logic          rdy;
   logic          forward;
   logic          backward;
   logic [DW-1:0] x;
   logic [DW-1:0] e;
   logic          vld;
   logic [DW-1:0] y;

   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_y;
   logic [DW-1:0] out_err;
   logic          timeout;

   modport master (
      input  in_valid, in_data, in_last, tgt, vld, y, out_ready,
      output in_ready, rdy, forward, backward, x, e,
             out_valid, out_y, out_err, timeout
   );

   modport slave (
      output in_valid, in_data, in_last, tgt, vld, y, out_ready,
      input  in_ready, rdy, forward, backward, x, e,
             out_valid, out_y, out_err, timeout
   );
endinterface

// File: rtl/core_feeder.sv
// Purpose : buffers one N-word vector from the host, replays it to the core as a
//           forward pass, captures y, optionally forms the scaled error and
//           replays the vector again as a backward (weight-update) pass.
// Latency : first input beat to out_valid = N + N + vld delay + 1 + N + 1 cycles
//           (training build); N + N + vld delay + 1 without training.
// Backpressure: in_ready drops once a vector is loaded until the host takes the
//           result; out_y/out_err hold while out_valid && !out_ready.
// Ports   : clk, rst (synchronous, active-low), bus (core_feeder_if.master).
// Macro   : FEEDER_TRAIN_EN enables the ERR/BWD training path; when undefined the
//           block is inference only (backward, e, out_err tied to 0, tgt unused).
module core_feeder #(
   parameter int N        = 100,
   parameter int DW       = 16,
   parameter int LR_SHIFT = 4,
   parameter int TIMEOUT  = 64
) (
   input  logic          clk,
   input  logic          rst,
   core_feeder_if.master bus
);

   localparam int IW = $clog2(N + 1);
   localparam int AW = (N > 1) ? $clog2(N) : 1;
   localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      FWD,
      WAIT_Y,
      ERR,
      BWD,
      DONE
   } state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [WW-1:0] wcnt_q, wcnt_d;
   logic [DW-1:0] out_y_q, out_y_d;
   logic          timeout_q, timeout_d;
   logic [DW-1:0] vec_mem [N];

   logic          in_ready;
   logic          accept;
   logic          load_end;
   logic [IW-1:0] wr_idx;

`ifdef FEEDER_TRAIN_EN
   logic [DW-1:0]        tgt_q, tgt_d;
   logic [DW-1:0]        err_q, err_d;
   logic [DW:0]          raw;
   logic signed [DW-1:0] sat;
   logic [DW-1:0]        e_calc;
`else
   logic unused_tgt;
   assign unused_tgt = ^bus.tgt;
`endif

   // in_ready is also gated by rst so the host sees no acceptance while reset is held.
   assign in_ready = rst && ((state_q == IDLE) || ((state_q == LOAD) && (idx_q < IW'(N))));
   assign accept   = bus.in_valid && in_ready;
   // IDLE always writes slot 0, regardless of where the counter was left.
   assign wr_idx   = (state_q == IDLE) ? '0 : idx_q;
   // The N-th word ends the load even without in_last; this also covers N=1.
   assign load_end = accept && (bus.in_last || (wr_idx == IW'(N - 1)));

   // Vector buffer: no reset needed, contents are rewritten before every replay.
   // A short vector clears all higher slots in the same cycle as its last word,
   // so padding is finished before FWD begins.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int m = 0; m < N; m++) begin
            if (IW'(m) == wr_idx) begin
               vec_mem[m] <= bus.in_data;
            end else if (load_end && (IW'(m) > wr_idx)) begin
               vec_mem[m] <= '0;
            end
         end
      end
   end

`ifdef FEEDER_TRAIN_EN
   // raw = tgt - y at DW+1 bits; overflow shows up as the top two bits differing.
   always_comb begin
      raw = {tgt_q[DW-1], tgt_q} - {out_y_q[DW-1], out_y_q};
      sat = raw[DW-1:0];
      if (raw[DW] != raw[DW-1]) begin
         sat = raw[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      end
      e_calc = sat >>> LR_SHIFT;
   end
`endif

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      wcnt_d    = wcnt_q;
      out_y_d   = out_y_q;
      timeout_d = timeout_q;
`ifdef FEEDER_TRAIN_EN
      tgt_d     = tgt_q;
      err_d     = err_q;
`endif
      case (state_q)
         IDLE, LOAD: begin
            if (accept) begin
               if (load_end) begin
`ifdef FEEDER_TRAIN_EN
                  tgt_d   = bus.tgt;
`endif
                  idx_d   = '0;
                  state_d = FWD;
               end else begin
                  idx_d   = wr_idx + 1'b1;
                  state_d = LOAD;
               end
            end
         end
         FWD: begin
            // vld during the forward pass is ignored; only WAIT_Y listens.
            if (idx_q == IW'(N - 1)) begin
               idx_d   = '0;
               wcnt_d  = '0;
               state_d = WAIT_Y;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         WAIT_Y: begin
            if (bus.vld) begin
               out_y_d = bus.y;
`ifdef FEEDER_TRAIN_EN
               state_d = ERR;
`else
               state_d = DONE;
`endif
            end else if (wcnt_q == WW'(TIMEOUT - 1)) begin
               timeout_d = 1'b1;
               out_y_d   = '0;
`ifdef FEEDER_TRAIN_EN
               err_d     = '0;
`endif
               state_d   = DONE;
            end else begin
               wcnt_d = wcnt_q + 1'b1;
            end
         end
`ifdef FEEDER_TRAIN_EN
         ERR: begin
            err_d   = e_calc;
            idx_d   = '0;
            state_d = BWD;
         end
         BWD: begin
            if (idx_q == IW'(N - 1)) begin
               idx_d   = '0;
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
`endif
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         wcnt_q    <= '0;
         out_y_q   <= '0;
         timeout_q <= 1'b0;
`ifdef FEEDER_TRAIN_EN
         tgt_q     <= '0;
         err_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         wcnt_q    <= wcnt_d;
         out_y_q   <= out_y_d;
         timeout_q <= timeout_d;
`ifdef FEEDER_TRAIN_EN
         tgt_q     <= tgt_d;
         err_q     <= err_d;
`endif
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.forward   = (state_q == FWD);
`ifdef FEEDER_TRAIN_EN
   assign bus.backward  = (state_q == BWD);
   assign bus.e         = (state_q == BWD) ? err_q : '0;
   assign bus.out_err   = err_q;
`else
   assign bus.backward  = 1'b0;
   assign bus.e         = '0;
   assign bus.out_err   = '0;
`endif
   assign bus.rdy       = bus.forward || bus.backward;
   assign bus.x         = bus.rdy ? vec_mem[idx_q[AW-1:0]] : '0;
   assign bus.out_valid = (state_q == DONE);
   assign bus.out_y     = out_y_q;
   assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_core_feeder.sv
// Purpose : directed self-checking bench for core_feeder with N=4, TIMEOUT=64.
// Latency : inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: out_ready is held low in DONE on selected vectors.
module tb_core_feeder;
   localparam int N  = 4;
   localparam int DW = 16;

`ifdef FEEDER_TRAIN_EN
   localparam bit TRAIN = 1'b1;
`else
   localparam bit TRAIN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_chk  = 0;
   int   n_pass = 0;
   logic [DW-1:0] vec [N];

   core_feeder_if #(.DW(DW)) bus ();

   core_feeder #(.N(N), .DW(DW), .LR_SHIFT(4), .TIMEOUT(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Loads vec[0..cnt-1], checks the forward replay, answers as the core after
   // y_dly WAIT_Y cycles (y_dly < 0: never), checks training beats and result.
   task automatic run_vec(input string tag, input int cnt, input logic [DW-1:0] tv,
                          input int y_dly, input logic [DW-1:0] yv,
                          input logic [DW-1:0] exp_e_train, input int hold,
                          input bit vld_in_fwd);
      logic [DW-1:0] exp_x;
      logic [DW-1:0] exp_y;
      logic [DW-1:0] exp_e;
      exp_e = TRAIN ? exp_e_train : '0;
      for (int k = 0; k < cnt; k++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = vec[k];
         bus.in_last  = (k == cnt - 1);
         bus.tgt      = tv;
         chk({tag, "_ld_in_ready"}, bus.in_ready, 1);
         tick();
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.tgt      = 16'h5555;
      for (int k = 0; k < N; k++) begin
         exp_x = (k < cnt) ? vec[k] : '0;
         if (vld_in_fwd) begin
            bus.vld = 1'b1;
            bus.y   = 16'h1234;
         end
         chk({tag, "_fwd_forward"}, bus.forward, 1);
         chk({tag, "_fwd_backward"}, bus.backward, 0);
         chk({tag, "_fwd_x"}, bus.x, exp_x);
         chk({tag, "_fwd_e"}, bus.e, 0);
         chk({tag, "_fwd_in_ready"}, bus.in_ready, 0);
         tick();
      end
      bus.vld = 1'b0;
      if (y_dly >= 0) begin
         for (int d = 0; d < y_dly; d++) begin
            chk({tag, "_wait_rdy"}, bus.rdy, 0);
            chk({tag, "_wait_out_valid"}, bus.out_valid, 0);
            tick();
         end
         bus.vld = 1'b1;
         bus.y   = yv;
         chk({tag, "_wait_rdy"}, bus.rdy, 0);
         tick();
         bus.vld = 1'b0;
         bus.y   = '0;
         exp_y   = yv;
         if (TRAIN) begin
            chk({tag, "_err_rdy"}, bus.rdy, 0);
            tick();
            for (int k = 0; k < N; k++) begin
               exp_x = (k < cnt) ? vec[k] : '0;
               chk({tag, "_bwd_backward"}, bus.backward, 1);
               chk({tag, "_bwd_forward"}, bus.forward, 0);
               chk({tag, "_bwd_x"}, bus.x, exp_x);
               chk({tag, "_bwd_e"}, bus.e, exp_e);
               tick();
            end
         end
         chk({tag, "_out_err"}, bus.out_err, exp_e);
      end else begin
         for (int d = 0; d < 64; d++) begin
            chk({tag, "_to_rdy"}, bus.rdy, 0);
            chk({tag, "_to_out_valid"}, bus.out_valid, 0);
            if (d == 63) chk({tag, "_to_flag_early"}, bus.timeout, 0);
            tick();
         end
         exp_y = '0;
         chk({tag, "_to_flag"}, bus.timeout, 1);
         chk({tag, "_to_backward"}, bus.backward, 0);
      end
      chk({tag, "_out_valid"}, bus.out_valid, 1);
      chk({tag, "_out_y"}, bus.out_y, exp_y);
      for (int h = 0; h < hold; h++) begin
         tick();
         chk({tag, "_hold_out_valid"}, bus.out_valid, 1);
         chk({tag, "_hold_out_y"}, bus.out_y, exp_y);
         if (y_dly >= 0) chk({tag, "_hold_out_err"}, bus.out_err, exp_e);
         chk({tag, "_hold_in_ready"}, bus.in_ready, 0);
         chk({tag, "_hold_backward"}, bus.backward, 0);
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk({tag, "_idle_out_valid"}, bus.out_valid, 0);
      chk({tag, "_idle_in_ready"}, bus.in_ready, 1);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_last   = 1'b0;
      bus.tgt       = '0;
      bus.vld       = 1'b0;
      bus.y         = '0;
      bus.out_ready = 1'b0;
      rst = 1'b0;
      tick();
      tick();
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_rdy", bus.rdy, 0);
      chk("rst_forward", bus.forward, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_y", bus.out_y, 0);
      chk("rst_out_err", bus.out_err, 0);
      chk("rst_timeout", bus.timeout, 0);
      rst = 1'b1;
      tick();
      chk("idle_in_ready", bus.in_ready, 1);

      // Full vector, y two cycles after FWD: e = (0x0800-0x0500)>>>4 = 0x0030.
      vec = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
      run_vec("t1", 4, 16'h0800, 2, 16'h0500, 16'h0030, 0, 1'b0);

      // Short vector padded with zeros; vld during FWD ignored.
      // e = (0x0100-0x0300) = 0xFE00 >>> 4 = 0xFFE0.
      vec = '{16'h0100, 16'h0200, 16'hDEAD, 16'hBEEF};
      run_vec("t2", 2, 16'h0100, 0, 16'h0300, 16'hFFE0, 0, 1'b1);

      // Positive saturation 0x7FFF - 0x8000 -> 0x7FFF, e = 0x07FF; host stalls 10 cycles.
      vec = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
      run_vec("t3", 4, 16'h7FFF, 1, 16'h8000, 16'h07FF, 10, 1'b0);

      // Negative saturation 0x8000 - 0x7FFF -> 0x8000, e = 0xF800.
      vec = '{16'hFF00, 16'h0080, 16'h8000, 16'h7FFF};
      run_vec("t4", 4, 16'h8000, 3, 16'h7FFF, 16'hF800, 0, 1'b0);

      // Core never answers: timeout after 64 WAIT_Y cycles, out_y forced to 0.
      vec = '{16'h0001, 16'h0002, 16'h0003, 16'h0000};
      run_vec("t5", 3, 16'h0000, -1, 16'h0000, 16'h0000, 3, 1'b0);
      chk("t5_timeout_sticky", bus.timeout, 1);

      // Reset mid-FWD.
      vec = '{16'h0A00, 16'h0B00, 16'h0C00, 16'h0D00};
      for (int k = 0; k < N; k++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = vec[k];
         bus.in_last  = (k == N - 1);
         tick();
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      chk("t6_fwd0_x", bus.x, 16'h0A00);
      tick();
      chk("t6_fwd1_forward", bus.forward, 1);
      rst = 1'b0;
      tick();
      chk("t6_rst_forward", bus.forward, 0);
      chk("t6_rst_rdy", bus.rdy, 0);
      chk("t6_rst_in_ready", bus.in_ready, 0);
      chk("t6_rst_timeout", bus.timeout, 0);
      tick();
      chk("t6_rst_hold_in_ready", bus.in_ready, 0);
      rst = 1'b1;
      tick();
      chk("t6_post_in_ready", bus.in_ready, 1);
      chk("t6_post_timeout", bus.timeout, 0);
      chk("t6_post_out_valid", bus.out_valid, 0);
      chk("t6_post_forward", bus.forward, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
